// File: rtl/uart_pkg.sv
// Shared UART definitions: default field widths and the baud configuration
// record written by the register file and consumed by uart_baud_gen.
package uart_pkg;

  localparam int unsigned DivWDef  = 16;  // integer clock divisor width
  localparam int unsigned OsrWDef  = 4;   // oversample-ratio field width
  localparam int unsigned FracWDef = 4;   // fractional divisor width

  // Baud configuration as held in the register file.
  typedef struct packed {
    logic [DivWDef-1:0]  divisor;  // acq period minus 1, in clk cycles
    logic [FracWDef-1:0] frac;     // extra period per acq tick, 1/2^FracWDef clk units
    logic [OsrWDef-1:0]  osr;      // acq ticks per bit minus 1
  } uart_cfg_t;

endpackage

// File: rtl/uart_frac_accum.sv
// Fractional divisor accumulator for uart_baud_gen.
// Adds the shadowed fractional divisor on every acq terminal and flags that the
// following acq period must be one clk longer whenever the sum carries out.
//
// Ports:
//   clk       system clock
//   rst       asynchronous, active-low reset
//   load_i    reload the fractional shadow from frac_i
//   frac_i    fractional period extension per acq tick
//   clr_i     clear accumulator and stretch (idle or resync)
//   step_i    acq terminal reached this cycle
//   stretch_o next acq period is one clk longer
module uart_frac_accum
  import uart_pkg::*;
#(
  parameter int unsigned FRAC_W = FracWDef
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [FRAC_W-1:0] frac_i,
  input  logic              clr_i,
  input  logic              step_i,
  output logic              stretch_o
);

  logic [FRAC_W-1:0] frac_s_q;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              stretch_q, stretch_d;
  logic [FRAC_W:0]   sum;

  always_comb begin
    sum       = {1'b0, acc_q} + {1'b0, frac_s_q};
    acc_d     = acc_q;
    stretch_d = stretch_q;
    if (clr_i) begin
      acc_d     = '0;
      stretch_d = 1'b0;
    end else if (step_i) begin
      acc_d     = sum[FRAC_W-1:0];
      stretch_d = sum[FRAC_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frac_s_q  <= '0;
      acc_q     <= '0;
      stretch_q <= 1'b0;
    end else begin
      if (load_i) frac_s_q <= frac_i;
      acc_q     <= acc_d;
      stretch_q <= stretch_d;
    end
  end

  assign stretch_o = stretch_q;

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud-rate generator: produces the RX oversample strobe (acq_o), the TX
// bit strobe (baud_o) and a mid-bit sample strobe (mid_o) from the system clock,
// with programmable divisor, oversampling ratio and an RX phase-resync input.
//
// Build option: define UART_BAUD_FRAC_EN to enable the fractional divisor
// (uart_frac_accum). Without it frac_i is ignored and the acq period is exactly
// divisor+1 clk; the port list is identical in both builds.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-low reset
//   en_i       generator enable
//   divisor_i  acq period minus 1, in clk cycles
//   frac_i     fractional period extension per acq tick
//   osr_i      acq ticks per bit minus 1
//   resync_i   single-clk pulse restarting the bit phase
//   acq_o      oversample strobe
//   baud_o     bit strobe, on the last acq_o of a bit
//   mid_o      mid-bit strobe, on acq_o index osr>>1
//   active_o   registered enable
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W  = DivWDef,
  parameter int unsigned OSR_W  = OsrWDef,
  parameter int unsigned FRAC_W = FracWDef
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [DIV_W-1:0]  divisor_i,
  input  logic [FRAC_W-1:0] frac_i,
  input  logic [OSR_W-1:0]  osr_i,
  input  logic              resync_i,
  output logic              acq_o,
  output logic              baud_o,
  output logic              mid_o,
  output logic              active_o
);

  logic             en_q;
  logic [DIV_W-1:0] div_s_q;
  logic [OSR_W-1:0] osr_s_q;
  // One bit wider than the divisor so a stretched maximum divisor still fits.
  logic [DIV_W:0]   cnt_q, cnt_d;
  logic [DIV_W:0]   target;
  logic [OSR_W-1:0] os_q, os_d;
  logic             acq_q, acq_d;
  logic             baud_q, baud_d;
  logic             mid_q, mid_d;
  logic             stretch;
  logic             clr;
  logic             load;
  logic             terminal;

  // Idle or resync clears the phase; resync beats a simultaneous terminal.
  assign clr      = ~en_q | resync_i;
  // Config is live while idle, otherwise it only changes at a bit boundary.
  assign load     = ~en_q | baud_q;
  assign target   = {1'b0, div_s_q} + {{DIV_W{1'b0}}, stretch};
  assign terminal = ~clr & (cnt_q == target);

`ifdef UART_BAUD_FRAC_EN
  uart_frac_accum #(
    .FRAC_W (FRAC_W)
  ) u_frac_accum (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .frac_i    (frac_i),
    .clr_i     (clr),
    .step_i    (terminal),
    .stretch_o (stretch)
  );
`else
  logic unused_frac;
  assign unused_frac = ^frac_i;
  assign stretch     = 1'b0;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    os_d   = os_q;
    acq_d  = 1'b0;
    baud_d = 1'b0;
    mid_d  = 1'b0;
    if (clr) begin
      cnt_d = '0;
      os_d  = '0;
    end else if (terminal) begin
      cnt_d  = '0;
      acq_d  = 1'b1;
      baud_d = (os_q == osr_s_q);
      mid_d  = (os_q == (osr_s_q >> 1));
      os_d   = baud_d ? '0 : os_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_s_q <= '0;
      osr_s_q <= '0;
    end else if (load) begin
      div_s_q <= divisor_i;
      osr_s_q <= osr_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q   <= 1'b0;
      cnt_q  <= '0;
      os_q   <= '0;
      acq_q  <= 1'b0;
      baud_q <= 1'b0;
      mid_q  <= 1'b0;
    end else begin
      en_q   <= en_i;
      cnt_q  <= cnt_d;
      os_q   <= os_d;
      acq_q  <= acq_d;
      baud_q <= baud_d;
      mid_q  <= mid_d;
    end
  end

  assign acq_o    = acq_q;
  assign baud_o   = baud_q;
  assign mid_o    = mid_q;
  assign active_o = en_q;

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
Parametrised baud-rate generator for the UART core. It produces the shared RX oversample strobe and the TX bit strobe from the system clock. Compared with the fixed 1:8 generator it adds:
- programmable oversampling ratio
- fractional divisor
- a mid-bit sample strobe
- a phase-resync input for RX start-bit alignment

It sits between the UART register file (divisor, ratio, enable) and the TX/RX shift engines.

Parameters:
DIV_W, 16, width of integer clock divisor
OSR_W, 4, width of oversample-ratio field (ratio = osr_i+1, max 2^OSR_W)
FRAC_W, 4, width of fractional divisor (units of 1/2^FRAC_W clk)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
en_i  input  1  generator enable, active high
divisor_i  input  DIV_W  acq period minus 1, in clk cycles
frac_i  input  FRAC_W  fractional period extension per acq tick
osr_i  input  OSR_W  acq ticks per bit minus 1
resync_i  input  1  single-clk pulse: restart bit phase (RX start-edge detect)
acq_o  output  1  oversample strobe, one-clk pulse
baud_o  output  1  bit strobe, one-clk pulse, coincident with the last acq_o of a bit
mid_o  output  1  mid-bit strobe, one-clk pulse, coincident with acq_o at index osr_i>>1
active_o  output  1  registered enable (en_q), status for register file

Behaviour:
- Reset (rst=0, async): en_q, acq counter, os counter, frac accumulator, stretch flag, shadow config all 0. acq_o, baud_o, mid_o, active_o are 0.
- en_i is registered into en_q (1 clk latency); active_o = en_q.
- en_q=0 (idle):
  - counters, accumulator and stretch are held at 0; all strobes are 0.
  - Shadow regs load divisor_i/frac_i/osr_i every cycle.
- en_q=1 (run):
  - Shadow config reloads only on a cycle where baud_o is asserted. Config writes mid-bit therefore take effect at the next bit boundary.
  - acq counter (DIV_W) counts 0..target. target = div_s, or div_s+1 when stretch=1.
  - At terminal: counter←0 and acq_o←1 for 1 clk.
  - Otherwise counter+1 and acq_o←0.
  - div_s=0 with no stretch gives acq_o every clk.
- Fractional rule, applied on each terminal:
  - {carry,acc} ← acc + frac_s (FRAC_W+1 bits); stretch ← carry.
  - Average acq period = div_s+1+frac_s/2^FRAC_W clk.
- os counter (OSR_W) advances on each acq_o.
  - baud_o←1 on the acq tick where os==osr_s; os then wraps to 0.
  - mid_o←1 on the acq tick where os==(osr_s>>1).
  - osr_s=0: baud_o and mid_o both coincide with every acq_o.
- First-strobe latency: with en_i sampled high at edge 0, frac_s=0, and resync_i and baud_o not asserted, acq_o is high in the cycle after edge div_s+1.
- resync_i=1 while en_q=1: acq counter, os counter, acc and stretch clear to 0. Strobes are 0 that cycle. resync wins over a simultaneous terminal. Counting restarts on the next edge.
- resync_i while en_q=0: ignored.
- en_i deasserted mid-bit: en_q falls one clk later. A strobe already registered in that cycle still completes; state then clears.
- Arithmetic:
  - all counters are unsigned and wrap only via explicit terminal compare, never by overflow;
  - div_s=2^DIV_W-1 with stretch=1 must yield a 2^DIV_W+1 clk period, so the counter compare is done at DIV_W+1 bits.

Optional Feature:
UART_BAUD_FRAC_EN
- Defined: fractional accumulator and stretch logic as above.
- Undefined: accumulator and stretch are removed; frac_i is ignored; acq period is exactly div_s+1 clk; the port list is unchanged.

Decomposition:
- Shared package uart_pkg: DIV_W/OSR_W/FRAC_W defaults, plus a cfg struct typedef {divisor, frac, osr} used by the register file and this block.
- Natural sub-module: uart_frac_accum, containing the accumulator, carry/stretch and reload enable. It is instantiated only under UART_BAUD_FRAC_EN.

Test Plan:
- Basic rate: div=9, frac=0, osr=7, en=1 → acq_o every 10 clk; baud_o every 80 clk; mid_o at acq index 3; first acq_o after edge 10 from enable sample.
- Fractional: div=3, frac=8 (FRAC_W=4) → acq periods alternate 4,5 clk; 16 ticks span 72 clk. With macro undefined → constant 4.
- Resync: assert resync_i at counter=5, os=4 (div=9) → strobes 0 that cycle; next acq_o 10 clk later; next mid_o/baud_o at acq indices 3/7 from restart. Resync on terminal cycle → no acq_o.
- Config reload: change div 9→4 mid-bit → old period holds until baud_o; new 5-clk period starts after it.
- Boundaries: div=0, osr=0 → acq_o=baud_o=mid_o=1 every clk. div=0xFFFF, frac=15 → periods 65536/65537 clk, no wrap error.
- Enable/reset: drop en_i mid-bit → strobes stop within 2 clk, counters read 0. Async rst low mid-cycle → outputs 0 immediately. Restart gives the latency from the basic-rate scenario.
